// File: rtl/credit_accumulator.sv
// rtl/credit_accumulator.sv - coin credit accumulator with vend and change/refund handshake
// Collects coins, dispenses on a funded vend request and returns change or refund via valid/ack.
module credit_accumulator #(
   parameter int AMT_W      = 8,
   parameter int COIN0_VAL  = 1,
   parameter int COIN1_VAL  = 5,
   parameter int COIN2_VAL  = 10,
   parameter int MAX_CREDIT = 99
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_coin_valid,
   input  logic [1:0]       i_coin_sel,
   input  logic             i_cancel,
   input  logic [AMT_W-1:0] i_price,
   input  logic             i_vend_req,
   input  logic             i_change_ack,
   output logic [AMT_W-1:0] o_credit,
   output logic             o_enough_money,
   output logic             o_dispense,
   output logic             o_coin_reject,
   output logic             o_change_valid,
   output logic [AMT_W-1:0] o_change_amt,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      REFUND  = 2'd3
   } state_t;

   localparam logic [AMT_W-1:0] C_COIN0 = AMT_W'(COIN0_VAL);
   localparam logic [AMT_W-1:0] C_COIN1 = AMT_W'(COIN1_VAL);
   localparam logic [AMT_W-1:0] C_COIN2 = AMT_W'(COIN2_VAL);
   localparam logic [AMT_W:0]   C_MAX   = (AMT_W+1)'(MAX_CREDIT);

   state_t           r_state, w_state_n;
   logic [AMT_W-1:0] r_credit, w_credit_n;
   logic [AMT_W-1:0] r_price_q, w_price_q_n;
   logic [AMT_W-1:0] r_change_amt, w_change_amt_n;
   logic             r_enough, w_enough_n;
   logic             r_dispense, w_dispense_n;
   logic             r_coin_reject, w_coin_reject_n;
   logic             r_change_valid, w_change_valid_n;
   logic             r_busy, w_busy_n;

   logic             w_coin_legal;
   logic [AMT_W-1:0] w_coin_val;
   logic [AMT_W:0]   w_sum;

   always_comb begin
      w_coin_legal = 1'b1;
      w_coin_val   = C_COIN0;
      case (i_coin_sel)
         2'd0:    w_coin_val = C_COIN0;
         2'd1:    w_coin_val = C_COIN1;
         2'd2:    w_coin_val = C_COIN2;
         default: w_coin_legal = 1'b0;
      endcase
   end

   // One extra bit so the overflow test against MAX_CREDIT can never wrap
   assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_val};

   always_comb begin
      w_state_n        = r_state;
      w_credit_n       = r_credit;
      w_price_q_n      = r_price_q;
      w_change_amt_n   = r_change_amt;
      w_change_valid_n = r_change_valid;
      w_dispense_n     = 1'b0;
      w_coin_reject_n  = i_coin_valid && !w_coin_legal;

      case (r_state)
         IDLE: begin
            if (i_coin_valid && w_coin_legal) begin
               w_credit_n = w_coin_val;
               w_state_n  = COLLECT;
            end
         end
         COLLECT: begin
            if (i_cancel) begin
               w_change_amt_n   = r_credit;
               w_change_valid_n = 1'b1;
               w_state_n        = REFUND;
               w_coin_reject_n  = i_coin_valid;
            end else if (i_vend_req && r_enough) begin
               w_price_q_n     = i_price;
               w_dispense_n    = 1'b1;
               w_state_n       = VEND;
               w_coin_reject_n = i_coin_valid;
            end else if (i_coin_valid && w_coin_legal) begin
               if (w_sum <= C_MAX) begin
                  w_credit_n = w_sum[AMT_W-1:0];
               end else begin
                  w_coin_reject_n = 1'b1;
               end
            end
         end
         VEND: begin
            w_coin_reject_n = i_coin_valid;
            w_credit_n      = '0;
            if (r_credit > r_price_q) begin
               w_change_amt_n   = r_credit - r_price_q;
               w_change_valid_n = 1'b1;
               w_state_n        = REFUND;
            end else begin
               w_state_n = IDLE;
            end
         end
         REFUND: begin
            w_coin_reject_n = i_coin_valid;
            if (i_change_ack) begin
               w_change_valid_n = 1'b0;
               w_change_amt_n   = '0;
               w_credit_n       = '0;
               w_state_n        = IDLE;
            end
         end
         default: begin
            w_state_n = IDLE;
         end
      endcase

      w_enough_n = (r_state != IDLE) && (r_credit >= i_price);
      w_busy_n   = (w_state_n == VEND) || (w_state_n == REFUND);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= IDLE;
         r_credit       <= '0;
         r_price_q      <= '0;
         r_change_amt   <= '0;
         r_enough       <= 1'b0;
         r_dispense     <= 1'b0;
         r_coin_reject  <= 1'b0;
         r_change_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_n;
         r_credit       <= w_credit_n;
         r_price_q      <= w_price_q_n;
         r_change_amt   <= w_change_amt_n;
         r_enough       <= w_enough_n;
         r_dispense     <= w_dispense_n;
         r_coin_reject  <= w_coin_reject_n;
         r_change_valid <= w_change_valid_n;
         r_busy         <= w_busy_n;
      end
   end

   assign o_credit       = r_credit;
   assign o_enough_money = r_enough;
   assign o_dispense     = r_dispense;
   assign o_coin_reject  = r_coin_reject;
   assign o_change_valid = r_change_valid;
   assign o_change_amt   = r_change_amt;
   assign o_busy         = r_busy;

endmodule

// File: tb/tb_credit_accumulator.sv
// tb/tb_credit_accumulator.sv - scoreboard bench for credit_accumulator
// Expected reject/dispense/change events are queued by stimulus and popped by a monitor.
module tb_credit_accumulator;

   localparam int AMT_W = 8;
   localparam int K_REJ = 0;
   localparam int K_DISP = 1;
   localparam int K_CHG = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             coin_valid = 1'b0;
   logic [1:0]       coin_sel = 2'd0;
   logic             cancel = 1'b0;
   logic [AMT_W-1:0] price = '0;
   logic             vend_req = 1'b0;
   logic             change_ack = 1'b0;
   logic [AMT_W-1:0] credit;
   logic             enough_money;
   logic             dispense;
   logic             coin_reject;
   logic             change_valid;
   logic [AMT_W-1:0] change_amt;
   logic             busy;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   credit_accumulator #(
      .AMT_W(AMT_W), .COIN0_VAL(1), .COIN1_VAL(5), .COIN2_VAL(10), .MAX_CREDIT(99)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_coin_valid(coin_valid), .i_coin_sel(coin_sel),
      .i_cancel(cancel), .i_price(price), .i_vend_req(vend_req), .i_change_ack(change_ack),
      .o_credit(credit), .o_enough_money(enough_money), .o_dispense(dispense),
      .o_coin_reject(coin_reject), .o_change_valid(change_valid), .o_change_amt(change_amt),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic expect_ev(input int kind, input int val);
      exp_q.push_back('{kind, val});
   endtask

   task automatic pop_check(input int kind, input int val);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL unexpected_event kind %0d val %0d expected none", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val) begin
            n_errors++;
            $display("FAIL event got kind %0d val %0d expected kind %0d val %0d",
                     kind, val, e.kind, e.val);
         end
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (coin_reject) pop_check(K_REJ, 0);
         if (dispense) pop_check(K_DISP, 0);
         if (change_valid && change_ack) pop_check(K_CHG, int'(change_amt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input int sel);
      coin_valid = 1'b1;
      coin_sel   = 2'(sel);
      tick();
      coin_valid = 1'b0;
   endtask

   task automatic vend();
      vend_req = 1'b1;
      tick();
      vend_req = 1'b0;
   endtask

   task automatic ack(input int amt);
      expect_ev(K_CHG, amt);
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
   endtask

   initial begin
      #12;
      check("reset_credit", int'(credit), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_enough", int'(enough_money), 0);
      check("reset_change_valid", int'(change_valid), 0);
      rst = 1'b0;
      tick();

      // Test 1: 5+10+1 against price 15, change 1
      price = 8'd15;
      coin(1);
      check("t1_credit5", int'(credit), 5);
      coin(2);
      check("t1_credit15", int'(credit), 15);
      check("t1_enough_lag", int'(enough_money), 0);
      tick();
      check("t1_enough_rise", int'(enough_money), 1);
      coin(0);
      check("t1_credit16", int'(credit), 16);
      expect_ev(K_DISP, 0);
      vend();
      check("t1_dispense", int'(dispense), 1);
      check("t1_busy_vend", int'(busy), 1);
      tick();
      check("t1_dispense_off", int'(dispense), 0);
      check("t1_change_valid", int'(change_valid), 1);
      check("t1_change_amt", int'(change_amt), 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_hold_valid", int'(change_valid), 1);
         check("t1_hold_amt", int'(change_amt), 1);
      end
      ack(1);
      check("t1_idle_valid", int'(change_valid), 0);
      check("t1_idle_credit", int'(credit), 0);
      check("t1_idle_busy", int'(busy), 0);

      // Test 2: underfunded vend ignored, then exact vend
      price = 8'd20;
      coin(2);
      coin(1);
      check("t2_credit15", int'(credit), 15);
      vend();
      check("t2_no_dispense", int'(dispense), 0);
      check("t2_no_busy", int'(busy), 0);
      coin(1);
      check("t2_credit20", int'(credit), 20);
      tick();
      check("t2_enough", int'(enough_money), 1);
      expect_ev(K_DISP, 0);
      vend();
      check("t2_dispense", int'(dispense), 1);
      tick();
      check("t2_no_change", int'(change_valid), 0);
      check("t2_idle_busy", int'(busy), 0);
      check("t2_idle_credit", int'(credit), 0);

      // Test 3: MAX_CREDIT boundary and illegal selector, price above MAX
      price = 8'd200;
      for (int i = 0; i < 9; i++) coin(2);
      coin(1);
      check("t3_credit95", int'(credit), 95);
      expect_ev(K_REJ, 0);
      coin(2);
      check("t3_reject_pulse", int'(coin_reject), 1);
      check("t3_credit_kept", int'(credit), 95);
      coin(0);
      check("t3_credit96", int'(credit), 96);
      check("t3_reject_off", int'(coin_reject), 0);
      expect_ev(K_REJ, 0);
      coin(3);
      check("t3_illegal_credit", int'(credit), 96);
      check("t3_never_enough", int'(enough_money), 0);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("t3_refund_amt", int'(change_amt), 96);
      ack(96);

      // Test 4: cancel with simultaneous coin
      price = 8'd50;
      coin(2);
      coin(1);
      coin(0);
      check("t4_credit16", int'(credit), 16);
      expect_ev(K_REJ, 0);
      cancel     = 1'b1;
      coin_valid = 1'b1;
      coin_sel   = 2'd1;
      tick();
      cancel     = 1'b0;
      coin_valid = 1'b0;
      check("t4_change_valid", int'(change_valid), 1);
      check("t4_change_amt", int'(change_amt), 16);
      check("t4_no_dispense", int'(dispense), 0);
      tick();
      tick();
      check("t4_amt_held", int'(change_amt), 16);
      ack(16);

      // Test 5: inputs ignored in REFUND, then reset mid-refund
      price = 8'd5;
      coin(2);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("t5_refund_amt", int'(change_amt), 10);
      expect_ev(K_REJ, 0);
      coin_valid = 1'b1;
      coin_sel   = 2'd0;
      cancel     = 1'b1;
      vend_req   = 1'b1;
      tick();
      coin_valid = 1'b0;
      cancel     = 1'b0;
      vend_req   = 1'b0;
      check("t5_amt_unchanged", int'(change_amt), 10);
      check("t5_valid_held", int'(change_valid), 1);
      check("t5_no_dispense", int'(dispense), 0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t5_rst_credit", int'(credit), 0);
      check("t5_rst_valid", int'(change_valid), 0);
      check("t5_rst_amt", int'(change_amt), 0);
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_reject", int'(coin_reject), 0);
      rst = 1'b0;
      tick();
      check("t5_post_credit", int'(credit), 0);
      coin(1);
      check("t5_idle_accept", int'(credit), 5);

      tick();
      tick();
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
